// File: rtl/npc_bpred.sv
// Next-PC unit: registered fetch PC, JAL/BHT prediction at IF, redirect on EX mispredict.
// Optional macro NPC_BHT_EN: when defined, conditional branches use a 2-bit counter BHT.
module npc_bpred #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int              BHT_DEPTH = 16,
  localparam int             BHT_IDX_W = $clog2(BHT_DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            if_br,
  input  logic            if_jal,
  input  logic [XLEN-1:0] if_imm,
  output logic            if_pred_taken,
  output logic [XLEN-1:0] pc_out,
  input  logic            ex_valid,
  input  logic [1:0]      ex_npc_op,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_alu_c,
  input  logic            ex_pred_taken,
  output logic [XLEN-1:0] ex_pc4,
  output logic [XLEN-1:0] ex_auipc,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
);

  localparam logic [1:0] OP_SEQ  = 2'b00;
  localparam logic [1:0] OP_JALR = 2'b01;
  localparam logic [1:0] OP_JAL  = 2'b10;
  localparam logic [1:0] OP_BR   = 2'b11;
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] pred_target;
  logic            pred;
  logic            br_pred;
  logic            ex_taken;

  assign pc_out        = pc_q;
  assign pc_plus4      = pc_q + FOUR;
  assign br_target     = pc_q + if_imm;
  assign if_pred_taken = pred;
  assign ex_pc4        = ex_pc + FOUR;
  assign ex_auipc      = ex_pc + ex_imm;
  assign ex_taken      = ex_alu_c[0];

`ifdef NPC_BHT_EN
  logic [1:0]           bht [BHT_DEPTH];
  logic [BHT_IDX_W-1:0] if_idx;
  logic [BHT_IDX_W-1:0] ex_idx;
  logic                 bht_upd;

  assign if_idx  = pc_q[BHT_IDX_W+1:2];
  assign ex_idx  = ex_pc[BHT_IDX_W+1:2];
  // IF reads the pre-update counter; an EX write lands at the edge.
  assign br_pred = bht[if_idx][1];
  assign bht_upd = ex_valid && (ex_npc_op == OP_BR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
    end else if (bht_upd) begin
      if (ex_taken) begin
        if (bht[ex_idx] != 2'b11) bht[ex_idx] <= bht[ex_idx] + 2'd1;
      end else begin
        if (bht[ex_idx] != 2'b00) bht[ex_idx] <= bht[ex_idx] - 2'd1;
      end
    end
  end
`else
  logic [BHT_IDX_W-1:0] unused_idx;

  assign unused_idx = pc_q[BHT_IDX_W+1:2];
  assign br_pred    = 1'b0;
`endif

  always_comb begin
    pred        = 1'b0;
    pred_target = pc_plus4;
    if (if_jal) begin
      pred        = 1'b1;
      pred_target = br_target;
    end else if (if_br) begin
      pred = br_pred;
      if (br_pred) pred_target = br_target;
    end
  end

  // redirect is a one-cycle command that outranks stall: the PC loads redirect_pc
  // at the next edge regardless of stall, and IF/ID are flushed by the pipe.
  always_comb begin
    redirect    = 1'b0;
    redirect_pc = '0;
    if (ex_valid) begin
      case (ex_npc_op)
        OP_JALR: begin
          redirect    = 1'b1;
          redirect_pc = {ex_alu_c[XLEN-1:1], 1'b0};
        end
        OP_BR: begin
          redirect    = (ex_taken != ex_pred_taken);
          redirect_pc = ex_taken ? ex_auipc : ex_pc4;
        end
        OP_SEQ, OP_JAL: begin
          redirect    = 1'b0;
          redirect_pc = '0;
        end
        default: begin
          redirect    = 1'b0;
          redirect_pc = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (redirect) begin
      pc_q <= redirect_pc;
    end else if (!stall) begin
      pc_q <= pred_target;
    end
  end

endmodule

// File: tb/tb_npc_bpred.sv
// Directed bench for npc_bpred; expectations follow the BHT build when NPC_BHT_EN is defined.
module tb_npc_bpred;

`ifdef NPC_BHT_EN
  localparam bit BHT_ON = 1'b1;
`else
  localparam bit BHT_ON = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        if_br;
  logic        if_jal;
  logic [31:0] if_imm;
  logic        if_pred_taken;
  logic [31:0] pc_out;
  logic        ex_valid;
  logic [1:0]  ex_npc_op;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_alu_c;
  logic        ex_pred_taken;
  logic [31:0] ex_pc4;
  logic [31:0] ex_auipc;
  logic        redirect;
  logic [31:0] redirect_pc;

  int checks = 0;
  int passes = 0;
  logic [31:0] exp_q[$];

  npc_bpred #(.XLEN(32), .RESET_PC(32'h0000_0000), .BHT_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .if_br(if_br), .if_jal(if_jal), .if_imm(if_imm),
    .if_pred_taken(if_pred_taken), .pc_out(pc_out),
    .ex_valid(ex_valid), .ex_npc_op(ex_npc_op), .ex_pc(ex_pc),
    .ex_imm(ex_imm), .ex_alu_c(ex_alu_c), .ex_pred_taken(ex_pred_taken),
    .ex_pc4(ex_pc4), .ex_auipc(ex_auipc),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic drive_idle();
    stall = 0; if_br = 0; if_jal = 0; if_imm = 0;
    ex_valid = 0; ex_npc_op = 0; ex_pc = 0; ex_imm = 0; ex_alu_c = 0; ex_pred_taken = 0;
  endtask

  task automatic drive_ex(input logic [1:0] op, input logic [31:0] pc, input logic [31:0] imm,
                          input logic [31:0] alu, input logic pt);
    ex_valid = 1; ex_npc_op = op; ex_pc = pc; ex_imm = imm; ex_alu_c = alu; ex_pred_taken = pt;
  endtask

  task automatic jump_to(input logic [31:0] a);
    @(negedge clk);
    drive_idle();
    drive_ex(2'b01, 32'h0, 32'h0, a, 1'b0);
    @(posedge clk); #1;
    drive_idle();
  endtask

  task automatic test_reset();
    logic [31:0] e;
    @(negedge clk);
    drive_idle();
    rst_n = 0;
    drive_ex(2'b01, 32'h0, 32'h0, 32'h80, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (pc_out !== 32'h0) $display("FAIL reset_pc: got %h want %h", pc_out, 32'h0); else passes++;
    @(negedge clk);
    drive_idle();
    rst_n = 1;
    #1;
    checks++; if (pc_out !== 32'h0) $display("FAIL reset_release: got %h want %h", pc_out, 32'h0); else passes++;
    checks++; if (if_pred_taken !== 1'b0) $display("FAIL reset_pred: got %b want 0", if_pred_taken); else passes++;
    checks++; if (redirect !== 1'b0) $display("FAIL bubble_redirect: got %b want 0", redirect); else passes++;
    checks++; if (redirect_pc !== 32'h0) $display("FAIL bubble_redirect_pc: got %h want 0", redirect_pc); else passes++;
    exp_q.push_back(32'h4); exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++; if (pc_out !== e) $display("FAIL seq_fetch: got %h want %h", pc_out, e); else passes++;
    end
  endtask

  task automatic test_jal();
    jump_to(32'h10);
    checks++; if (pc_out !== 32'h10) $display("FAIL jalr_setup: got %h want %h", pc_out, 32'h10); else passes++;
    @(negedge clk);
    drive_idle();
    if_jal = 1; if_imm = 32'h20;
    #1;
    checks++; if (if_pred_taken !== 1'b1) $display("FAIL jal_pred: got %b want 1", if_pred_taken); else passes++;
    @(posedge clk); #1;
    checks++; if (pc_out !== 32'h30) $display("FAIL jal_pc: got %h want %h", pc_out, 32'h30); else passes++;
    @(negedge clk);
    drive_idle();
    if_jal = 1; if_br = 1; if_imm = 32'h8;
    drive_ex(2'b10, 32'h10, 32'h20, 32'h0, 1'b1);
    #1;
    checks++; if (redirect !== 1'b0) $display("FAIL jal_ex_redirect: got %b want 0", redirect); else passes++;
    checks++; if (ex_pc4 !== 32'h14) $display("FAIL jal_ex_pc4: got %h want %h", ex_pc4, 32'h14); else passes++;
    checks++; if (ex_auipc !== 32'h30) $display("FAIL jal_ex_auipc: got %h want %h", ex_auipc, 32'h30); else passes++;
    checks++; if (if_pred_taken !== 1'b1) $display("FAIL jal_wins_pred: got %b want 1", if_pred_taken); else passes++;
    @(posedge clk); #1;
    checks++; if (pc_out !== 32'h38) $display("FAIL jal_wins_pc: got %h want %h", pc_out, 32'h38); else passes++;
  endtask

  task automatic test_branch_training();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive_idle();
      drive_ex(2'b11, 32'h40, 32'h100, 32'h1, 1'b0);
      #1;
      checks++; if (redirect !== 1'b1) $display("FAIL train_redirect: got %b want 1", redirect); else passes++;
      checks++; if (redirect_pc !== 32'h140) $display("FAIL train_redirect_pc: got %h want %h", redirect_pc, 32'h140); else passes++;
      @(posedge clk); #1;
      checks++; if (pc_out !== 32'h140) $display("FAIL train_pc: got %h want %h", pc_out, 32'h140); else passes++;
    end
    jump_to(32'h40);
    @(negedge clk);
    drive_idle();
    if_br = 1; if_imm = 32'h100;
    #1;
    checks++; if (if_pred_taken !== BHT_ON) $display("FAIL trained_pred: got %b want %b", if_pred_taken, BHT_ON); else passes++;
    @(posedge clk); #1;
    checks++; if (pc_out !== (BHT_ON ? 32'h140 : 32'h44)) $display("FAIL trained_pc: got %h want %h", pc_out, (BHT_ON ? 32'h140 : 32'h44)); else passes++;
    @(negedge clk);
    drive_idle();
    drive_ex(2'b11, 32'h40, 32'h100, 32'h0, 1'b1);
    #1;
    checks++; if (redirect !== 1'b1) $display("FAIL nt_redirect: got %b want 1", redirect); else passes++;
    checks++; if (redirect_pc !== 32'h44) $display("FAIL nt_redirect_pc: got %h want %h", redirect_pc, 32'h44); else passes++;
    @(posedge clk); #1;
    checks++; if (pc_out !== 32'h44) $display("FAIL nt_pc: got %h want %h", pc_out, 32'h44); else passes++;
  endtask

  task automatic test_same_cycle();
    jump_to(32'h40);
    @(negedge clk);
    drive_idle();
    if_br = 1; if_imm = 32'h100;
    drive_ex(2'b11, 32'h40, 32'h100, 32'h0, 1'b0);
    #1;
    checks++; if (if_pred_taken !== BHT_ON) $display("FAIL same_cycle_pred: got %b want %b", if_pred_taken, BHT_ON); else passes++;
    checks++; if (redirect !== 1'b0) $display("FAIL same_cycle_redirect: got %b want 0", redirect); else passes++;
    @(posedge clk); #1;
    checks++; if (pc_out !== (BHT_ON ? 32'h140 : 32'h44)) $display("FAIL same_cycle_pc: got %h want %h", pc_out, (BHT_ON ? 32'h140 : 32'h44)); else passes++;
    jump_to(32'h40);
    @(negedge clk);
    drive_idle();
    if_br = 1; if_imm = 32'h100;
    #1;
    checks++; if (if_pred_taken !== 1'b0) $display("FAIL bht_visible: got %b want 0", if_pred_taken); else passes++;
  endtask

  task automatic test_saturation();
    logic [6:0] hi_pat;
    hi_pat = 7'b1111100;
    jump_to(32'h40);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive_idle();
      stall = 1; if_br = 1; if_imm = 32'h100;
      if (i < 5) drive_ex(2'b11, 32'h40, 32'h100, 32'h0, 1'b0);
      #1;
      checks++; if (if_pred_taken !== 1'b0) $display("FAIL sat_lo_pred[%0d]: got %b want 0", i, if_pred_taken); else passes++;
      checks++; if (redirect !== 1'b0) $display("FAIL sat_lo_redirect[%0d]: got %b want 0", i, redirect); else passes++;
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive_idle();
      stall = 1; if_br = 1; if_imm = 32'h100;
      ex_npc_op = 2'b11; ex_pc = 32'h40; ex_imm = 32'h100; ex_alu_c = 32'h1; ex_pred_taken = 1'b0;
      #1;
      checks++; if (redirect !== 1'b0) $display("FAIL bubble_br_redirect[%0d]: got %b want 0", i, redirect); else passes++;
      checks++; if (redirect_pc !== 32'h0) $display("FAIL bubble_br_pc[%0d]: got %h want 0", i, redirect_pc); else passes++;
    end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive_idle();
      stall = 1; if_br = 1; if_imm = 32'h100;
      if (i < 5) drive_ex(2'b11, 32'h40, 32'h100, 32'h1, 1'b1);
      else if (i == 5) drive_ex(2'b11, 32'h40, 32'h100, 32'h0, 1'b0);
      #1;
      checks++; if (if_pred_taken !== (BHT_ON & hi_pat[i])) $display("FAIL sat_hi_pred[%0d]: got %b want %b", i, if_pred_taken, BHT_ON & hi_pat[i]); else passes++;
      checks++; if (redirect !== 1'b0) $display("FAIL sat_hi_redirect[%0d]: got %b want 0", i, redirect); else passes++;
    end
    @(posedge clk); #1;
    checks++; if (pc_out !== 32'h40) $display("FAIL stall_hold: got %h want %h", pc_out, 32'h40); else passes++;
  endtask

  task automatic test_jalr_stall();
    @(negedge clk);
    drive_idle();
    stall = 1;
    drive_ex(2'b01, 32'h200, 32'h0, 32'h1235, 1'b0);
    #1;
    checks++; if (redirect !== 1'b1) $display("FAIL jalr_redirect: got %b want 1", redirect); else passes++;
    checks++; if (redirect_pc !== 32'h1234) $display("FAIL jalr_target: got %h want %h", redirect_pc, 32'h1234); else passes++;
    checks++; if (ex_pc4 !== 32'h204) $display("FAIL jalr_link: got %h want %h", ex_pc4, 32'h204); else passes++;
    @(posedge clk); #1;
    checks++; if (pc_out !== 32'h1234) $display("FAIL jalr_beats_stall: got %h want %h", pc_out, 32'h1234); else passes++;
    @(negedge clk);
    drive_idle();
    stall = 1;
    @(posedge clk); #1;
    checks++; if (pc_out !== 32'h1234) $display("FAIL stall_hold2: got %h want %h", pc_out, 32'h1234); else passes++;
  endtask

  task automatic test_wrap();
    jump_to(32'hFFFF_FFFC);
    @(negedge clk);
    drive_idle();
    @(posedge clk); #1;
    checks++; if (pc_out !== 32'h0) $display("FAIL wrap_seq: got %h want %h", pc_out, 32'h0); else passes++;
    @(negedge clk);
    drive_idle();
    drive_ex(2'b00, 32'hFFFF_FFFC, 32'h8, 32'h0, 1'b0);
    #1;
    checks++; if (ex_pc4 !== 32'h0) $display("FAIL wrap_pc4: got %h want %h", ex_pc4, 32'h0); else passes++;
    checks++; if (ex_auipc !== 32'h4) $display("FAIL wrap_auipc: got %h want %h", ex_auipc, 32'h4); else passes++;
    checks++; if (redirect !== 1'b0) $display("FAIL seq_redirect: got %b want 0", redirect); else passes++;
    jump_to(32'hFFFF_FFF0);
    @(negedge clk);
    drive_idle();
    if_jal = 1; if_imm = 32'h20;
    @(posedge clk); #1;
    checks++; if (pc_out !== 32'h10) $display("FAIL wrap_jal: got %h want %h", pc_out, 32'h10); else passes++;
  endtask

  initial begin
    rst_n = 0;
    drive_idle();
    test_reset();
    test_jal();
    test_branch_training();
    test_same_cycle();
    test_saturation();
    test_jalr_stall();
    test_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
